// File: rtl/ddr2_cmd_issue_if.sv
// Scheduler-to-issue request bundle: one abstract DDR2 command per cycle.
// Valid/ready handshake; the command issues when valid & ready.
interface ddr2_cmd_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [1:0]  req_ba;
  logic [14:0] req_addr;

  modport master (
    output req_valid, req_cmd, req_ba, req_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_ba, req_addr,
    output req_ready
  );
endinterface

// File: rtl/ddr2_cmd_issue.sv
// DDR2 command-issue stage: JEDEC timing gates, open-bank tracking, registered pins.
// Optional DDR2_CMD_ERR_EN: illegal requests are accepted, dropped, and flagged on cmd_err.
module ddr2_cmd_issue #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RAS = 12,
  parameter int T_RRD = 3,
  parameter int T_RFC = 51,
  parameter int T_MRD = 2,
  parameter int T_CCD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke_en,
  ddr2_cmd_issue_if.slave req,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [14:0] addr,
  output logic [3:0]  bank_open
`ifdef DDR2_CMD_ERR_EN
  ,
  output logic        cmd_err
`endif
);

  typedef enum logic [2:0] {
    C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_PREA, C_REF, C_MRS
  } cmd_e;

  typedef logic [5:0] tmr_t;

  localparam tmr_t RCD_L = tmr_t'(T_RCD - 1);
  localparam tmr_t RP_L  = tmr_t'(T_RP - 1);
  localparam tmr_t RAS_L = tmr_t'(T_RAS - 1);
  localparam tmr_t RRD_L = tmr_t'(T_RRD - 1);
  localparam tmr_t RFC_L = tmr_t'(T_RFC - 1);
  localparam tmr_t MRD_L = tmr_t'(T_MRD - 1);
  localparam tmr_t CCD_L = tmr_t'(T_CCD - 1);

  tmr_t rcd [4];
  tmr_t rp  [4];
  tmr_t ras [4];
  tmr_t rrd, ccd, busy;

  cmd_e       cmd;
  logic [1:0] rb;
  logic       open_b, any_open, busy0;
  logic       rp_all0, ras_all0;
  logic       ok, illegal, fire;

  assign cmd      = cmd_e'(req.req_cmd);
  assign rb       = req.req_ba;
  assign open_b   = bank_open[rb];
  assign any_open = |bank_open;
  assign busy0    = (busy == '0);

  function automatic tmr_t dec(tmr_t t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  always_comb begin
    rp_all0  = 1'b1;
    ras_all0 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (rp[b] != '0) rp_all0 = 1'b0;
      if (bank_open[b] && ras[b] != '0) ras_all0 = 1'b0;
    end
  end

  always_comb begin
    ok      = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (cmd == C_NOP): ok = 1'b1;
      (cmd == C_ACT): begin
        ok = !open_b && rp[rb] == '0 && rrd == '0 && busy0;
        illegal = open_b;
      end
      (cmd == C_RD), (cmd == C_WR): begin
        ok = open_b && rcd[rb] == '0 && ccd == '0 && busy0;
        illegal = !open_b;
      end
      (cmd == C_PRE):  ok = (!open_b || ras[rb] == '0) && busy0;
      (cmd == C_PREA): ok = ras_all0 && busy0;
      (cmd == C_REF), (cmd == C_MRS): begin
        ok = !any_open && rp_all0 && busy0;
        illegal = any_open;
      end
      default: ;
    endcase
  end

`ifdef DDR2_CMD_ERR_EN
  assign req.req_ready = cke & (ok | illegal);
`else
  assign req.req_ready = cke & ok;
`endif

  assign fire = req.req_valid & req.req_ready & ~illegal & (cmd != C_NOP);

  // Reload wins over decrement: the later NBA in this block overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcd       <= '{default: '0};
      rp        <= '{default: '0};
      ras       <= '{default: '0};
      rrd       <= '0;
      ccd       <= '0;
      busy      <= '0;
      bank_open <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        rcd[b] <= dec(rcd[b]);
        rp[b]  <= dec(rp[b]);
        ras[b] <= dec(ras[b]);
      end
      rrd  <= dec(rrd);
      ccd  <= dec(ccd);
      busy <= dec(busy);
      if (fire) begin
        unique case (1'b1)
          (cmd == C_ACT): begin
            rcd[rb]       <= RCD_L;
            ras[rb]       <= RAS_L;
            rrd           <= RRD_L;
            bank_open[rb] <= 1'b1;
          end
          (cmd == C_RD), (cmd == C_WR): ccd <= CCD_L;
          (cmd == C_PRE): begin
            rp[rb]        <= RP_L;
            bank_open[rb] <= 1'b0;
          end
          (cmd == C_PREA): begin
            rp        <= '{default: RP_L};
            bank_open <= '0;
          end
          (cmd == C_REF): busy <= RFC_L;
          (cmd == C_MRS): busy <= MRD_L;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cke   <= 1'b0;
      cs_n  <= 1'b1;
      ras_n <= 1'b1;
      cas_n <= 1'b1;
      we_n  <= 1'b1;
      ba    <= '0;
      addr  <= '0;
    end else begin
      cke   <= cke_en;
      cs_n  <= 1'b0;
      ras_n <= 1'b1;
      cas_n <= 1'b1;
      we_n  <= 1'b1;
      if (fire) begin
        ba   <= rb;
        addr <= req.req_addr;
        unique case (1'b1)
          (cmd == C_ACT): {ras_n, cas_n, we_n} <= 3'b011;
          (cmd == C_RD): begin
            {ras_n, cas_n, we_n} <= 3'b101;
            addr[10] <= 1'b0;
          end
          (cmd == C_WR): begin
            {ras_n, cas_n, we_n} <= 3'b100;
            addr[10] <= 1'b0;
          end
          (cmd == C_PRE): begin
            {ras_n, cas_n, we_n} <= 3'b010;
            addr[10] <= 1'b0;
          end
          (cmd == C_PREA): begin
            {ras_n, cas_n, we_n} <= 3'b010;
            addr[10] <= 1'b1;
          end
          (cmd == C_REF): {ras_n, cas_n, we_n} <= 3'b001;
          (cmd == C_MRS): {ras_n, cas_n, we_n} <= 3'b000;
          default: ;
        endcase
      end
    end
  end

`ifdef DDR2_CMD_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err <= 1'b0;
    else        cmd_err <= req.req_valid & req.req_ready & illegal;
  end
`endif

endmodule
